// File: rtl/cu_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control unit: FSM states, opcode
// match patterns, ALU and sign-extend codes, and instruction classes.
package cu_pkg;

    localparam int unsigned OpW = 11;

    // FSM state encoding; StTrap is reserved even when trapping is disabled.
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } cu_state_e;

    typedef enum logic [3:0] {
        ClsR,
        ClsI,
        ClsLoad,
        ClsStore,
        ClsShift,
        ClsB,
        ClsCbz,
        ClsCbnz,
        ClsIllegal
    } cu_class_e;

    // Match masks: B uses 6 opcode bits, CB 8, I 10, R/D all 11.
    localparam logic [OpW-1:0] MaskB  = 11'h7E0;
    localparam logic [OpW-1:0] MaskCb = 11'h7F8;
    localparam logic [OpW-1:0] MaskI  = 11'h7FE;
    localparam logic [OpW-1:0] MaskRd = 11'h7FF;

    localparam logic [OpW-1:0] OpAdd  = 11'h458;
    localparam logic [OpW-1:0] OpSub  = 11'h658;
    localparam logic [OpW-1:0] OpAnd  = 11'h450;
    localparam logic [OpW-1:0] OpOrr  = 11'h550;
    localparam logic [OpW-1:0] OpLdur = 11'h7C2;
    localparam logic [OpW-1:0] OpStur = 11'h7C0;
    localparam logic [OpW-1:0] OpLsl  = 11'h69B;
    localparam logic [OpW-1:0] OpLsr  = 11'h69A;
    localparam logic [OpW-1:0] OpB    = 11'h0A0;
    localparam logic [OpW-1:0] OpCbz  = 11'h5A0;
    localparam logic [OpW-1:0] OpCbnz = 11'h5A8;
    localparam logic [OpW-1:0] OpAddi = 11'h488;
    localparam logic [OpW-1:0] OpSubi = 11'h688;
    localparam logic [OpW-1:0] OpAndi = 11'h490;
    localparam logic [OpW-1:0] OpOrri = 11'h590;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluAnd  = 3'b010;
    localparam logic [2:0] AluOrr  = 3'b011;
    localparam logic [2:0] AluPass = 3'b100;
    localparam logic [2:0] AluLsl  = 3'b101;
    localparam logic [2:0] AluLsr  = 3'b110;

    localparam logic [1:0] SeuAlu = 2'b00;
    localparam logic [1:0] SeuD   = 2'b01;
    localparam logic [1:0] SeuB   = 2'b10;
    localparam logic [1:0] SeuCb  = 2'b11;

    function automatic logic op_match(input logic [OpW-1:0] op, input logic [OpW-1:0] pat,
                                      input logic [OpW-1:0] mask);
        return (op & mask) == pat;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational LEGv8 opcode decoder: instruction class plus the controls that
// depend only on the opcode. Shared with a future pipelined control unit.
module cu_decode
    import cu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 11
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output cu_class_e           cls_o,
    output logic [2:0]          alu_op_o,
    output logic                alu_src_o,
    output logic [1:0]          seu_o,
    output logic                reg2loc_o
);

    logic [OpW-1:0] op;
    assign op = OpW'(opcode_i);

    // Classify the opcode; anything unmatched is illegal with all controls low.
    always_comb begin
        cls_o     = ClsIllegal;
        alu_op_o  = AluAdd;
        alu_src_o = 1'b0;
        seu_o     = SeuAlu;
        reg2loc_o = 1'b0;
        if (op_match(op, OpAdd, MaskRd)) begin
            cls_o = ClsR;
        end else if (op_match(op, OpSub, MaskRd)) begin
            cls_o    = ClsR;
            alu_op_o = AluSub;
        end else if (op_match(op, OpAnd, MaskRd)) begin
            cls_o    = ClsR;
            alu_op_o = AluAnd;
        end else if (op_match(op, OpOrr, MaskRd)) begin
            cls_o    = ClsR;
            alu_op_o = AluOrr;
        end else if (op_match(op, OpLdur, MaskRd)) begin
            cls_o     = ClsLoad;
            alu_src_o = 1'b1;
            seu_o     = SeuD;
        end else if (op_match(op, OpStur, MaskRd)) begin
            cls_o     = ClsStore;
            alu_src_o = 1'b1;
            seu_o     = SeuD;
            reg2loc_o = 1'b1;
        end else if (op_match(op, OpLsl, MaskRd)) begin
            cls_o     = ClsShift;
            alu_op_o  = AluLsl;
            alu_src_o = 1'b1;
        end else if (op_match(op, OpLsr, MaskRd)) begin
            cls_o     = ClsShift;
            alu_op_o  = AluLsr;
            alu_src_o = 1'b1;
        end else if (op_match(op, OpAddi, MaskI)) begin
            cls_o     = ClsI;
            alu_src_o = 1'b1;
        end else if (op_match(op, OpSubi, MaskI)) begin
            cls_o     = ClsI;
            alu_op_o  = AluSub;
            alu_src_o = 1'b1;
        end else if (op_match(op, OpAndi, MaskI)) begin
            cls_o     = ClsI;
            alu_op_o  = AluAnd;
            alu_src_o = 1'b1;
        end else if (op_match(op, OpOrri, MaskI)) begin
            cls_o     = ClsI;
            alu_op_o  = AluOrr;
            alu_src_o = 1'b1;
        end else if (op_match(op, OpCbz, MaskCb)) begin
            // Rt is tested by passing it through the ALU to the zero flag.
            cls_o     = ClsCbz;
            alu_op_o  = AluPass;
            seu_o     = SeuCb;
            reg2loc_o = 1'b1;
        end else if (op_match(op, OpCbnz, MaskCb)) begin
            cls_o     = ClsCbnz;
            alu_op_o  = AluPass;
            seu_o     = SeuCb;
            reg2loc_o = 1'b1;
        end else if (op_match(op, OpB, MaskB)) begin
            cls_o = ClsB;
            seu_o = SeuB;
        end
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory ready handshake and a retired-instruction counter.
// Define CU_ILLEGAL_TRAP_EN to send unrecognised opcodes to a sticky TRAP state;
// otherwise they retire as NOPs.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 11,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                bus_irWr,
    output logic                bus_pcWr,
    output logic                bus_pcSrc,
    output logic                bus_reg2loc,
    output logic [1:0]          bus_seu,
    output logic                bus_aluSrc,
    output logic [ALUOP_W-1:0]  bus_aluOp,
    output logic                bus_memRd,
    output logic                bus_memWr,
    output logic                bus_memToReg,
    output logic                bus_regWr,
    output logic [CNT_W-1:0]    retired,
    output logic [2:0]          state_o
);

    cu_state_e           state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic [OPCODE_W-1:0] dec_opcode;
    logic [CNT_W-1:0]    retired_q;
    logic                retire;

    cu_class_e  cls;
    logic [2:0] dec_alu_op;
    logic       dec_alu_src;
    logic [1:0] dec_seu;
    logic       dec_reg2loc;

    // The latch is not loaded until the end of DECODE, so decode the live IR there.
    assign dec_opcode = (state_q == StDecode) ? opcode : opcode_q;

    cu_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode_i  (dec_opcode),
        .cls_o     (cls),
        .alu_op_o  (dec_alu_op),
        .alu_src_o (dec_alu_src),
        .seu_o     (dec_seu),
        .reg2loc_o (dec_reg2loc)
    );

    // Next state and retirement strobe.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: state_d = StExec;
            StExec: begin
                case (cls)
                    ClsR, ClsI, ClsShift: state_d = StWb;
                    ClsLoad, ClsStore:    state_d = StMem;
                    ClsB, ClsCbz, ClsCbnz: begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_d = StTrap;
`else
                        state_d = StFetch;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    if (cls == ClsLoad) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // State, opcode latch and retirement counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            opcode_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) opcode_q <= opcode;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Control outputs from state and decoded class; everything defaults low.
    always_comb begin
        bus_irWr     = 1'b0;
        bus_pcWr     = 1'b0;
        bus_pcSrc    = 1'b0;
        bus_reg2loc  = 1'b0;
        bus_seu      = SeuAlu;
        bus_aluSrc   = 1'b0;
        bus_aluOp    = '0;
        bus_memRd    = 1'b0;
        bus_memWr    = 1'b0;
        bus_memToReg = 1'b0;
        bus_regWr    = 1'b0;
        case (state_q)
            StFetch: begin
                bus_memRd = 1'b1;
                if (mem_ready) begin
                    bus_irWr = 1'b1;
                    bus_pcWr = 1'b1;
                end
            end
            StDecode: bus_reg2loc = dec_reg2loc;
            StExec: begin
                bus_reg2loc = dec_reg2loc;
                bus_seu     = dec_seu;
                bus_aluSrc  = dec_alu_src;
                bus_aluOp   = ALUOP_W'(dec_alu_op);
                case (cls)
                    ClsB: begin
                        bus_pcWr  = 1'b1;
                        bus_pcSrc = 1'b1;
                    end
                    ClsCbz: begin
                        bus_pcWr  = zero;
                        bus_pcSrc = 1'b1;
                    end
                    ClsCbnz: begin
                        bus_pcWr  = ~zero;
                        bus_pcSrc = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                // Keep the address path driven for the whole memory wait.
                bus_reg2loc = dec_reg2loc;
                bus_seu     = dec_seu;
                bus_aluSrc  = dec_alu_src;
                bus_aluOp   = ALUOP_W'(dec_alu_op);
                bus_memRd   = (cls == ClsLoad);
                bus_memWr   = (cls == ClsStore);
            end
            StWb: begin
                bus_regWr    = 1'b1;
                bus_memToReg = (cls == ClsLoad);
            end
            default: ;
        endcase
    end

    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu (4-bit retire counter so wrap is reachable).
// Control word order: irWr pcWr pcSrc reg2loc seu[1:0] aluSrc aluOp[2:0]
//                     memRd memWr memToReg regWr
module tb_multicycle_cu;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        bus_irWr, bus_pcWr, bus_pcSrc, bus_reg2loc, bus_aluSrc;
    logic [1:0]  bus_seu;
    logic [2:0]  bus_aluOp;
    logic        bus_memRd, bus_memWr, bus_memToReg, bus_regWr;
    logic [3:0]  retired;
    logic [2:0]  state_o;

    multicycle_cu #(
        .OPCODE_W (11),
        .ALUOP_W  (3),
        .CNT_W    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .bus_irWr     (bus_irWr),
        .bus_pcWr     (bus_pcWr),
        .bus_pcSrc    (bus_pcSrc),
        .bus_reg2loc  (bus_reg2loc),
        .bus_seu      (bus_seu),
        .bus_aluSrc   (bus_aluSrc),
        .bus_aluOp    (bus_aluOp),
        .bus_memRd    (bus_memRd),
        .bus_memWr    (bus_memWr),
        .bus_memToReg (bus_memToReg),
        .bus_regWr    (bus_regWr),
        .retired      (retired),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    localparam logic [10:0] OP_ADD = 11'h458, OP_SUB = 11'h658, OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0, OP_LSL = 11'h69B, OP_ORRI = 11'h590;
    localparam logic [10:0] OP_B = 11'h0A0, OP_CBZ = 11'h5A0, OP_JUNK = 11'h7FF;

    localparam logic [13:0] C_NONE    = 14'b0_0_0_0_00_0_000_0_0_0_0;
    localparam logic [13:0] C_F_WAIT  = 14'b0_0_0_0_00_0_000_1_0_0_0;
    localparam logic [13:0] C_F_GO    = 14'b1_1_0_0_00_0_000_1_0_0_0;
    localparam logic [13:0] C_D_RT    = 14'b0_0_0_1_00_0_000_0_0_0_0;
    localparam logic [13:0] C_E_SUB   = 14'b0_0_0_0_00_0_001_0_0_0_0;
    localparam logic [13:0] C_E_LSL   = 14'b0_0_0_0_00_1_101_0_0_0_0;
    localparam logic [13:0] C_E_ORRI  = 14'b0_0_0_0_00_1_011_0_0_0_0;
    localparam logic [13:0] C_E_LDUR  = 14'b0_0_0_0_01_1_000_0_0_0_0;
    localparam logic [13:0] C_M_LDUR  = 14'b0_0_0_0_01_1_000_1_0_0_0;
    localparam logic [13:0] C_E_STUR  = 14'b0_0_0_1_01_1_000_0_0_0_0;
    localparam logic [13:0] C_M_STUR  = 14'b0_0_0_1_01_1_000_0_1_0_0;
    localparam logic [13:0] C_E_CBZ1  = 14'b0_1_1_1_11_0_100_0_0_0_0;
    localparam logic [13:0] C_E_CBZ0  = 14'b0_0_1_1_11_0_100_0_0_0_0;
    localparam logic [13:0] C_E_B     = 14'b0_1_1_0_10_0_000_0_0_0_0;
    localparam logic [13:0] C_WB      = 14'b0_0_0_0_00_0_000_0_0_0_1;
    localparam logic [13:0] C_WB_LD   = 14'b0_0_0_0_00_0_000_0_0_1_1;

    typedef struct {
        logic [2:0]  st;
        logic [13:0] ctrl;
        logic [3:0]  ret;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [13:0] ctrl_obs;
    assign ctrl_obs = {bus_irWr, bus_pcWr, bus_pcSrc, bus_reg2loc, bus_seu, bus_aluSrc,
                       bus_aluOp, bus_memRd, bus_memWr, bus_memToReg, bus_regWr};

    // Monitor: each cycle the DUT presents outputs for a queued expectation, compare.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if ({state_o, ctrl_obs, retired} !== {e.st, e.ctrl, e.ret}) begin
                bad++;
                $display("FAIL %s: got st=%0d ctrl=%b ret=%0d, want st=%0d ctrl=%b ret=%0d",
                         e.name, state_o, ctrl_obs, retired, e.st, e.ctrl, e.ret);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic r, input logic [10:0] op, input logic z,
                        input logic rdy, input logic [2:0] st, input logic [13:0] c,
                        input logic [3:0] ret, input string nm);
        rst       = r;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        sb.push_back('{st, c, ret, nm});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1, 11'h000, 0, 0, 0, C_F_WAIT, 0, "reset");

        // ADD: 0,1,2,4 with a fetch stall first; opcode input scrambled after DECODE.
        step(0, OP_ADD,  0, 0, 0, C_F_WAIT, 0, "add_fwait");
        step(0, OP_ADD,  0, 1, 0, C_F_GO,   0, "add_fetch");
        step(0, OP_ADD,  0, 1, 1, C_NONE,   0, "add_dec");
        step(0, OP_JUNK, 0, 1, 2, C_NONE,   0, "add_exec");
        step(0, OP_JUNK, 0, 1, 4, C_WB,     0, "add_wb");

        step(0, OP_SUB,  0, 1, 0, C_F_GO,   1, "sub_fetch");
        step(0, OP_SUB,  0, 1, 1, C_NONE,   1, "sub_dec");
        step(0, OP_JUNK, 0, 1, 2, C_E_SUB,  1, "sub_exec");
        step(0, OP_JUNK, 0, 1, 4, C_WB,     1, "sub_wb");

        // LDUR with three not-ready MEM cycles: 8 cycles total.
        step(0, OP_LDUR, 0, 1, 0, C_F_GO,   2, "ld_fetch");
        step(0, OP_LDUR, 0, 1, 1, C_NONE,   2, "ld_dec");
        step(0, OP_JUNK, 0, 1, 2, C_E_LDUR, 2, "ld_exec");
        for (int i = 0; i < 3; i++) step(0, OP_JUNK, 0, 0, 3, C_M_LDUR, 2, "ld_mem_wait");
        step(0, OP_JUNK, 0, 1, 3, C_M_LDUR, 2, "ld_mem_go");
        step(0, OP_JUNK, 0, 1, 4, C_WB_LD,  2, "ld_wb");

        step(0, OP_CBZ,  0, 1, 0, C_F_GO,   3, "cbz1_fetch");
        step(0, OP_CBZ,  0, 1, 1, C_D_RT,   3, "cbz1_dec");
        step(0, OP_JUNK, 1, 1, 2, C_E_CBZ1, 3, "cbz1_exec");

        step(0, OP_CBZ,  1, 1, 0, C_F_GO,   4, "cbz0_fetch");
        step(0, OP_CBZ,  1, 1, 1, C_D_RT,   4, "cbz0_dec");
        step(0, OP_JUNK, 0, 1, 2, C_E_CBZ0, 4, "cbz0_exec");

        step(0, OP_LSL,  0, 1, 0, C_F_GO,   5, "lsl_fetch");
        step(0, OP_LSL,  0, 1, 1, C_NONE,   5, "lsl_dec");
        step(0, OP_JUNK, 0, 1, 2, C_E_LSL,  5, "lsl_exec");
        step(0, OP_JUNK, 0, 1, 4, C_WB,     5, "lsl_wb");

        step(0, OP_ORRI, 0, 1, 0, C_F_GO,   6, "orri_fetch");
        step(0, OP_ORRI, 0, 1, 1, C_NONE,   6, "orri_dec");
        step(0, OP_JUNK, 0, 1, 2, C_E_ORRI, 6, "orri_exec");
        step(0, OP_JUNK, 0, 1, 4, C_WB,     6, "orri_wb");

        // STUR completing in one MEM cycle: 4 cycles.
        step(0, OP_STUR, 0, 1, 0, C_F_GO,   7, "st_fetch");
        step(0, OP_STUR, 0, 1, 1, C_D_RT,   7, "st_dec");
        step(0, OP_JUNK, 0, 1, 2, C_E_STUR, 7, "st_exec");
        step(0, OP_JUNK, 0, 1, 3, C_M_STUR, 7, "st_mem");

        // STUR with reset during MEM, together with mem_ready.
        step(0, OP_STUR, 0, 1, 0, C_F_GO,   8, "strst_fetch");
        step(0, OP_STUR, 0, 1, 1, C_D_RT,   8, "strst_dec");
        step(0, OP_JUNK, 0, 1, 2, C_E_STUR, 8, "strst_exec");
        step(1, OP_JUNK, 0, 1, 3, C_M_STUR, 8, "strst_mem");
        step(0, OP_JUNK, 0, 0, 0, C_F_WAIT, 0, "strst_after");

        // Sixteen branches walk the 4-bit counter through 15 and back to 0.
        for (int i = 0; i < 16; i++) begin
            step(0, OP_B,    0, 1, 0, C_F_GO, 4'(i), "b_fetch");
            step(0, OP_B,    0, 1, 1, C_NONE, 4'(i), "b_dec");
            step(0, OP_JUNK, 0, 1, 2, C_E_B,  4'(i), "b_exec");
        end

        // Unrecognised opcode 0x000.
        step(0, 11'h000, 0, 1, 0, C_F_GO, 0, "wrap_fetch");
        step(0, 11'h000, 0, 1, 1, C_NONE, 0, "ill_dec");
        step(0, 11'h000, 0, 1, 2, C_NONE, 0, "ill_exec");
`ifdef CU_ILLEGAL_TRAP_EN
        step(0, 11'h000, 0, 1, 5, C_NONE, 0, "trap");
        step(0, OP_ADD,  1, 1, 5, C_NONE, 0, "trap_hold");
        step(1, OP_ADD,  0, 1, 5, C_NONE, 0, "trap_rst");
        step(0, OP_ADD,  0, 0, 0, C_F_WAIT, 0, "trap_after");
`else
        step(0, 11'h000, 0, 0, 0, C_F_WAIT, 1, "nop_retire");
`endif

        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
